// File: rtl/scrod_trg_pkg.sv
// Shared types and defaults for the SCROD trigger responder.
package scrod_trg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        BUSY_ST,
        ACK_ST,
        HOLD
    } trg_state_t;

    localparam int DEF_ACK_WIDTH    = 4;
    localparam int DEF_HOLDOFF      = 8;
    localparam int DEF_BUSY_TIMEOUT = 4096;
    localparam int DEF_CNT_W        = 16;

    // One timer serves BUSY_ST, ACK_ST and HOLD, so it must hold the largest of the three limits.
    function automatic int timer_width(input int busy_timeout, input int ack_width, input int holdoff);
        int m;
        m = busy_timeout;
        if (ack_width > m) m = ack_width;
        if (holdoff > m) m = holdoff;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scrod_trg_responder_if.sv
// Trigger link, digitizer handshake and slow-control readback of one SCROD responder.
interface scrod_trg_responder_if
    import scrod_trg_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             TRG_IN;
    logic             ACK_OUT;
    logic             ENABLE;
    logic             CLEAR;
    logic             DIG_TRIG;
    logic             DIG_DONE;
    logic             BUSY;
    logic [CNT_W-1:0] TRG_CNT;
    logic [CNT_W-1:0] MISSED_CNT;
    logic             TIMEOUT_FLAG;

    modport slave (
        input  TRG_IN, ENABLE, CLEAR, DIG_DONE,
        output ACK_OUT, DIG_TRIG, BUSY, TRG_CNT, MISSED_CNT, TIMEOUT_FLAG
    );

    modport master (
        output TRG_IN, ENABLE, CLEAR, DIG_DONE,
        input  ACK_OUT, DIG_TRIG, BUSY, TRG_CNT, MISSED_CNT, TIMEOUT_FLAG
    );

endinterface

// File: rtl/trg_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge strobe for asynchronous level inputs.
// After reset the strobe stays disarmed until the synchronized input has been seen low,
// so a line that is already high when reset releases never produces a false edge.
module trg_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic [1:0] fill;
    logic       armed;

    // Synchronize, track when sync2 holds real input data, arm on a genuine low, register the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~sync2);
            rise  <= sync2 & ~sync3 & armed;
        end
    end

endmodule

// File: rtl/scrod_trg_responder.sv
// SCROD endpoint of the trigger/acknowledge link: forwards one trigger to the digitizer,
// waits for readout, returns a fixed-width ACK, then holds off before rearming.
module scrod_trg_responder
    import scrod_trg_pkg::*;
#(
    parameter int ACK_WIDTH    = DEF_ACK_WIDTH,
    parameter int HOLDOFF      = DEF_HOLDOFF,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 CLK_42MHZ,
    input  logic                 RESET_N,
    scrod_trg_responder_if.slave bus
);
    localparam int TMR_W = timer_width(BUSY_TIMEOUT, ACK_WIDTH, HOLDOFF);
    localparam logic [TMR_W-1:0] BUSY_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_WIDTH - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    trg_state_t       state;
    trg_state_t       state_next;
    logic [TMR_W-1:0] timer;
    logic             trg_edge;
    logic             busy_last;
    logic             ack_last;
    logic             hold_last;
    logic             take_trig;
    logic             miss_trig;
    logic             timeout_set;
    logic             dig_trig_d;
    logic             ack_d;
    logic             busy_d;
    logic             dig_trig_q;
    logic             ack_q;
    logic             busy_q;
    logic             timeout_q;
    logic [CNT_W-1:0] trg_cnt_q;
    logic [CNT_W-1:0] missed_cnt_q;

    trg_sync_edge u_sync (
        .clk      (CLK_42MHZ),
        .rst_n    (RESET_N),
        .async_in (bus.TRG_IN),
        .rise     (trg_edge)
    );

    assign busy_last   = (timer == BUSY_LAST);
    assign ack_last    = (timer == ACK_LAST);
    assign hold_last   = (timer == HOLD_LAST);
    assign take_trig   = (state == IDLE) && trg_edge && bus.ENABLE;
    assign miss_trig   = (state != IDLE) && trg_edge && bus.ENABLE;
    assign timeout_set = (state == BUSY_ST) && !bus.DIG_DONE && busy_last;

    // State register plus the registered copies of the state-derived outputs.
    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            dig_trig_q <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_next;
            dig_trig_q <= dig_trig_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    // Next state; DIG_DONE outranks a timeout landing in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take_trig) state_next = TRIG;
            TRIG:    state_next = BUSY_ST;
            BUSY_ST: begin
                if (bus.DIG_DONE)   state_next = ACK_ST;
                else if (busy_last) state_next = HOLD;
            end
            ACK_ST:  if (ack_last) state_next = HOLD;
            HOLD:    if (hold_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they register cleanly.
    always_comb begin
        dig_trig_d = (state_next == TRIG);
        ack_d      = (state_next == ACK_ST);
        busy_d     = (state_next != IDLE);
    end

    // Shared timer: cleared on entry to TRIG, ACK_ST, HOLD and in IDLE; keeps running from TRIG into BUSY_ST.
    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            timer <= '0;
        end else if (state_next == IDLE || (state_next != state && state_next != BUSY_ST)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Readback counters and sticky timeout flag; CLEAR takes priority over any update.
    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            trg_cnt_q    <= '0;
            missed_cnt_q <= '0;
            timeout_q    <= 1'b0;
        end else if (bus.CLEAR) begin
            trg_cnt_q    <= '0;
            missed_cnt_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (take_trig) trg_cnt_q <= trg_cnt_q + 1'b1;
            if (miss_trig && missed_cnt_q != '1) missed_cnt_q <= missed_cnt_q + 1'b1;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    assign bus.DIG_TRIG     = dig_trig_q;
    assign bus.ACK_OUT      = ack_q;
    assign bus.BUSY         = busy_q;
    assign bus.TRG_CNT      = trg_cnt_q;
    assign bus.MISSED_CNT   = missed_cnt_q;
    assign bus.TIMEOUT_FLAG = timeout_q;

endmodule

// File: tb/tb_scrod_trg_responder.sv
// Directed bench for scrod_trg_responder: dut_a uses the defaults, dut_b uses
// BUSY_TIMEOUT=16 and CNT_W=4. Both see the same stimulus; each test checks one of them.
// Cycle r of a test is the interval just after the r-th rising edge; TRG_IN is raised in cycle 0.
module tb_scrod_trg_responder;
    import scrod_trg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trg_in = 1'b0;
    logic enable = 1'b1;
    logic clear = 1'b0;
    logic dig_done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_dig;
    int   n_ack;
    int   n_busy;
    logic prev_ack;

    always #5 clk = ~clk;

    scrod_trg_responder_if #(.CNT_W(16)) if_a ();
    scrod_trg_responder_if #(.CNT_W(4))  if_b ();

    assign if_a.TRG_IN   = trg_in;
    assign if_a.ENABLE   = enable;
    assign if_a.CLEAR    = clear;
    assign if_a.DIG_DONE = dig_done;
    assign if_b.TRG_IN   = trg_in;
    assign if_b.ENABLE   = enable;
    assign if_b.CLEAR    = clear;
    assign if_b.DIG_DONE = dig_done;

    scrod_trg_responder #(.CNT_W(16)) dut_a (
        .CLK_42MHZ (clk),
        .RESET_N   (rst_n),
        .bus       (if_a)
    );

    scrod_trg_responder #(.BUSY_TIMEOUT(16), .CNT_W(4)) dut_b (
        .CLK_42MHZ (clk),
        .RESET_N   (rst_n),
        .bus       (if_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        trg_in   = 1'b0;
        enable   = 1'b1;
        clear    = 1'b0;
        dig_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got time limit, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        // Reset values
        tick();
        check_output("reset ack_a",     32'(if_a.ACK_OUT), 0);
        check_output("reset dig_a",     32'(if_a.DIG_TRIG), 0);
        check_output("reset busy_a",    32'(if_a.BUSY), 0);
        check_output("reset flag_a",    32'(if_a.TIMEOUT_FLAG), 0);
        check_output("reset trgcnt_a",  32'(if_a.TRG_CNT), 0);
        check_output("reset missed_a",  32'(if_a.MISSED_CNT), 0);
        check_output("reset busy_b",    32'(if_b.BUSY), 0);
        check_output("reset trgcnt_b",  32'(if_b.TRG_CNT), 0);
        apply_reset();

        // Basic handshake: DIG_TRIG at 4, BUSY 4..32, ACK 21..24
        $display("[TB] basic handshake");
        trg_in = 1'b1;
        for (int r = 1; r <= 34; r++) begin
            tick();
            if (r == 5)  trg_in = 1'b0;
            dig_done = (r == 20);
            check_output($sformatf("basic dig_trig @%0d", r), 32'(if_a.DIG_TRIG), 32'(r == 4));
            check_output($sformatf("basic busy @%0d", r),     32'(if_a.BUSY), 32'(r >= 4 && r <= 32));
            check_output($sformatf("basic ack @%0d", r),      32'(if_a.ACK_OUT), 32'(r >= 21 && r <= 24));
        end
        check_output("basic trg_cnt", 32'(if_a.TRG_CNT), 1);
        check_output("basic missed",  32'(if_a.MISSED_CNT), 0);

        // Busy rejection: pulses at 0, 6, 12; DIG_DONE at 50
        $display("[TB] busy rejection");
        apply_reset();
        n_dig = 0; n_ack = 0; prev_ack = 1'b0;
        trg_in = 1'b1;
        for (int r = 1; r <= 80; r++) begin
            tick();
            trg_in   = ((r % 6) < 3) && (r < 18);
            dig_done = (r == 50);
            if (if_a.DIG_TRIG) n_dig++;
            if (if_a.ACK_OUT && !prev_ack) n_ack++;
            prev_ack = if_a.ACK_OUT;
        end
        check_output("reject dig_trig pulses", 32'(n_dig), 1);
        check_output("reject ack pulses",      32'(n_ack), 1);
        check_output("reject trg_cnt",         32'(if_a.TRG_CNT), 1);
        check_output("reject missed",          32'(if_a.MISSED_CNT), 2);
        check_output("reject busy end",        32'(if_a.BUSY), 0);

        // Timeout on dut_b: DIG_TRIG at 4, flag at 20, idle at 28, second trigger at 30 -> DIG_TRIG 34
        $display("[TB] readout timeout");
        apply_reset();
        trg_in = 1'b1;
        for (int r = 1; r <= 45; r++) begin
            tick();
            trg_in = (r < 3) || (r >= 30 && r < 33);
            check_output($sformatf("timeout flag @%0d", r), 32'(if_b.TIMEOUT_FLAG), 32'(r >= 20));
            check_output($sformatf("timeout ack @%0d", r),  32'(if_b.ACK_OUT), 0);
            check_output($sformatf("timeout dig @%0d", r),  32'(if_b.DIG_TRIG), 32'(r == 4 || r == 34));
            check_output($sformatf("timeout busy @%0d", r), 32'(if_b.BUSY), 32'((r >= 4 && r <= 27) || r >= 34));
        end
        check_output("timeout trg_cnt", 32'(if_b.TRG_CNT), 2);

        // Disabled: three triggers, nothing happens
        $display("[TB] disabled triggers");
        apply_reset();
        enable = 1'b0;
        n_dig = 0; n_busy = 0;
        trg_in = 1'b1;
        for (int r = 1; r <= 25; r++) begin
            tick();
            trg_in = ((r % 6) < 3) && (r < 18);
            if (if_a.DIG_TRIG) n_dig++;
            if (if_a.BUSY) n_busy++;
        end
        check_output("disabled dig_trig", 32'(n_dig), 0);
        check_output("disabled busy",     32'(n_busy), 0);
        check_output("disabled trg_cnt",  32'(if_a.TRG_CNT), 0);
        check_output("disabled missed",   32'(if_a.MISSED_CNT), 0);

        // CLEAR with the increment, early DIG_DONE lost, ENABLE dropped mid-sequence
        $display("[TB] clear, early done, enable drop");
        apply_reset();
        trg_in = 1'b1;
        for (int r = 1; r <= 30; r++) begin
            tick();
            trg_in   = (r < 3);
            clear    = (r == 3);
            dig_done = (r == 4) || (r == 10);
            enable   = (r < 6) || (r >= 20);
            if (r == 4) begin
                check_output("clear wins trg_cnt", 32'(if_a.TRG_CNT), 0);
                check_output("clear keeps dig_trig", 32'(if_a.DIG_TRIG), 1);
            end
            if (r == 10) check_output("early done busy", 32'(if_a.BUSY), 1);
            check_output($sformatf("mid ack @%0d", r), 32'(if_a.ACK_OUT), 32'(r >= 11 && r <= 14));
        end

        // 17 accepted triggers: dut_b (CNT_W=4) wraps to 1
        $display("[TB] counter wrap");
        apply_reset();
        for (int k = 1; k <= 17; k++) begin
            trg_in = 1'b1;
            for (int r = 1; r <= 21; r++) begin
                tick();
                trg_in   = (r < 3);
                dig_done = (r == 6);
            end
            if (k == 16) check_output("wrap trg_cnt_b at 16", 32'(if_b.TRG_CNT), 0);
        end
        check_output("wrap trg_cnt_b", 32'(if_b.TRG_CNT), 1);
        check_output("wrap trg_cnt_a", 32'(if_a.TRG_CNT), 17);
        check_output("wrap missed_b",  32'(if_b.MISSED_CNT), 0);

        // Five timed-out sequences with 4 misses each (last one in the final HOLD cycle)
        $display("[TB] missed saturation");
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            trg_in = 1'b1;
            for (int r = 1; r <= 31; r++) begin
                tick();
                trg_in = ((r % 6) < 3) && (r < 27);
            end
            if (k == 1) check_output("hold boundary missed_b", 32'(if_b.MISSED_CNT), 4);
        end
        check_output("saturate missed_b", 32'(if_b.MISSED_CNT), 15);
        check_output("saturate trg_cnt_b", 32'(if_b.TRG_CNT), 5);

        // Reset during the second ACK cycle with TRG_IN held high
        $display("[TB] reset mid-ack");
        apply_reset();
        trg_in = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            tick();
            dig_done = (r == 10);
        end
        check_output("pre-reset ack", 32'(if_a.ACK_OUT), 1);
        check_output("pre-reset trg_cnt", 32'(if_a.TRG_CNT), 1);
        rst_n = 1'b0;
        #1;
        check_output("async reset ack",     32'(if_a.ACK_OUT), 0);
        check_output("async reset busy",    32'(if_a.BUSY), 0);
        check_output("async reset trg_cnt", 32'(if_a.TRG_CNT), 0);
        tick();
        tick();
        rst_n = 1'b1;
        n_dig = 0; n_busy = 0;
        for (int r = 1; r <= 12; r++) begin
            tick();
            if (if_a.DIG_TRIG) n_dig++;
            if (if_a.BUSY) n_busy++;
        end
        check_output("held level no retrigger", 32'(n_dig), 0);
        check_output("held level no busy",      32'(n_busy), 0);
        trg_in = 1'b0;
        repeat (4) tick();
        trg_in = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            tick();
            check_output($sformatf("retrigger dig @%0d", r), 32'(if_a.DIG_TRIG), 32'(r == 4));
        end
        check_output("retrigger trg_cnt", 32'(if_a.TRG_CNT), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
